or_gate: RTL and testbench



---
 rtl/or_gate_pkg.sv | 30 +++
 rtl/or_gate_trit_max.sv | 34 +++
 rtl/or_gate.sv | 109 ++++++++++
 tb/tb_or_gate.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or_gate_pkg.sv
// -----------------------------------------------------------------------------
// or_gate_pkg
//
// Shared definitions for the ternary OR datapath.
//
// Contents:
//   trit_t        - 2-bit balanced-free ternary digit (00=0, 01=1, 10=2, 11=X)
//   TRIT_0..2     - legal trit codes
//   TRIT_X        - invalid code; poisons any result it touches
//   ERR_CNT_W     - width of the optional invalid-input counter
//   ERR_CNT_MAX   - saturation value of that counter
//   is_x()        - true when a trit carries the invalid code
// -----------------------------------------------------------------------------
package or_gate_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0 = 2'b00;
    localparam trit_t TRIT_1 = 2'b01;
    localparam trit_t TRIT_2 = 2'b10;
    localparam trit_t TRIT_X = 2'b11;

    localparam int unsigned ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    function automatic logic is_x(input trit_t t);
        return (t == TRIT_X);
    endfunction

endpackage : or_gate_pkg

// File: rtl/or_gate_trit_max.sv
// -----------------------------------------------------------------------------
// trit_max
//
// Single-trit ternary OR: the result is the larger of the two digits. An
// invalid digit on either side forces the invalid code on the output, so a
// corrupted operand can never masquerade as a legal value downstream.
//
// Ports:
//   a      in   trit_t   operand A digit
//   b      in   trit_t   operand B digit
//   result out  trit_t   max(a, b), or TRIT_X if either input is TRIT_X
// -----------------------------------------------------------------------------
module trit_max
    import or_gate_pkg::*;
(
    input  trit_t a,
    input  trit_t b,
    output trit_t result
);

    always_comb begin
        // NOTE: assigning a default before any branch guarantees every path
        // drives the output, so no latch can be inferred.
        result = TRIT_0;
        if (is_x(a) || is_x(b)) begin
            result = TRIT_X;
        end else if (a > b) begin
            result = a;
        end else begin
            result = b;
        end
    end

endmodule : trit_max

// File: rtl/or_gate.sv
// -----------------------------------------------------------------------------
// or_gate
//
// WIDTH-trit ternary OR with a combinational result and a valid-qualified
// registered copy. Each trit position is an independent trit_max instance;
// there is no interaction between positions.
//
// Parameters:
//   WIDTH    number of trits per operand (1..16)
//
// Ports:
//   clk      in   1          rising-edge clock for the registered outputs
//   rst_n    in   1          asynchronous active-low reset
//   a        in   2*WIDTH    operand A, trit i at bits [2i+1:2i]
//   b        in   2*WIDTH    operand B, same packing
//   valid_i  in   1          capture enable for c_q
//   c        out  2*WIDTH    combinational ternary OR of a and b
//   c_q      out  2*WIDTH    c captured on the last valid_i edge
//   valid_o  out  1          valid_i delayed by one clock
//   err      out  1          (ORGATE_INVALID_CHECK_EN only) sticky flag: a
//                            valid_i cycle carried an X trit on a or b
//   err_cnt  out  8          (ORGATE_INVALID_CHECK_EN only) saturating count
//                            of such cycles
//
// Build option:
//   ORGATE_INVALID_CHECK_EN  adds the err / err_cnt ports and their logic.
//   Without it the X-propagation behaviour of c is unchanged.
// -----------------------------------------------------------------------------
module or_gate
    import or_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0]   b,
    input  logic                 valid_i,
    output logic [2*WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0]   c_q,
    output logic                 valid_o
`ifdef ORGATE_INVALID_CHECK_EN
    ,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Combinational datapath: one trit_max per digit position.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_trit
        trit_max u_trit_max (
            .a      (a[2*i +: 2]),
            .b      (b[2*i +: 2]),
            .result (c[2*i +: 2])
        );
    end

    // -------------------------------------------------------------------------
    // Registered copy. Reset clears immediately, independent of clk, so the
    // outputs are known-zero for the whole time rst_n is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            valid_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            if (valid_i) begin
                c_q <= c;
            end
            valid_o <= valid_i;
        end
    end

`ifdef ORGATE_INVALID_CHECK_EN
    // -------------------------------------------------------------------------
    // Invalid-input monitor: flags any captured cycle whose operands carried
    // an X trit in any position. Only rst_n clears it.
    // -------------------------------------------------------------------------
    logic any_x;

    always_comb begin
        any_x = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (is_x(a[2*i +: 2]) || is_x(b[2*i +: 2])) begin
                any_x = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (valid_i && any_x) begin
            err <= 1'b1;
            // Saturate rather than wrap so a long fault burst never reads
            // back as a small count.
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule : or_gate

// File: tb/tb_or_gate.sv
// -----------------------------------------------------------------------------
// tb_or_gate
//
// Directed bench for or_gate. Two instances share clock, reset and valid_i:
// dut1 (WIDTH=1) and dut4 (WIDTH=4). Inputs change on the falling edge;
// registered outputs are sampled 1 time unit after the rising edge.
// Define ORGATE_INVALID_CHECK_EN to also exercise err / err_cnt.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_or_gate;

    logic       clk;
    logic       rst_n;
    logic       valid_i;
    logic [1:0] a1, b1, c1, c_q1;
    logic [7:0] a4, b4, c4, c_q4;
    logic       valid_o1, valid_o4;
`ifdef ORGATE_INVALID_CHECK_EN
    logic       err1, err4;
    logic [7:0] err_cnt1, err_cnt4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    or_gate #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a1),
        .b       (b1),
        .valid_i (valid_i),
        .c       (c1),
        .c_q     (c_q1),
        .valid_o (valid_o1)
`ifdef ORGATE_INVALID_CHECK_EN
        ,
        .err     (err1),
        .err_cnt (err_cnt1)
`endif
    );

    or_gate #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a4),
        .b       (b4),
        .valid_i (valid_i),
        .c       (c4),
        .c_q     (c_q4),
        .valid_o (valid_o4)
`ifdef ORGATE_INVALID_CHECK_EN
        ,
        .err     (err4),
        .err_cnt (err_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        a1 = 2'b01; b1 = 2'b10;
        a4 = 8'h00; b4 = 8'h00;
        #2;
        n_checks++;
        if (c_q1 !== 2'b00) begin n_fail++; $display("FAIL reset_c_q got=%b exp=00", c_q1); end
        n_checks++;
        if (valid_o1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o got=%b exp=0", valid_o1); end
        n_checks++;
        if (c1 !== 2'b10) begin n_fail++; $display("FAIL reset_c_live got=%b exp=10", c1); end
        // valid_i high across an edge while in reset must not capture
        valid_i = 1'b1;
        step_edge();
        n_checks++;
        if (c_q1 !== 2'b00 || valid_o1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_capture c_q=%b valid_o=%b exp=00/0", c_q1, valid_o1);
        end
`ifdef ORGATE_INVALID_CHECK_EN
        n_checks++;
        if (err1 !== 1'b0 || err_cnt1 !== 8'd0) begin
            n_fail++; $display("FAIL reset_err err=%b cnt=%0d exp=0/0", err1, err_cnt1);
        end
`endif
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [1:0] exp_tab [9];
        exp_tab = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a1 = 2'(i);
                b1 = 2'(j);
                #5;
                n_checks++;
                if (c1 !== exp_tab[i*3+j]) begin
                    n_fail++;
                    $display("FAIL table %0d|%0d got=%b exp=%b", i, j, c1, exp_tab[i*3+j]);
                end
            end
        end
        a1 = 2'b11; b1 = 2'b01; #5;
        n_checks++;
        if (c1 !== 2'b11) begin n_fail++; $display("FAIL x_or_1 got=%b exp=11", c1); end
        a1 = 2'b10; b1 = 2'b11; #5;
        n_checks++;
        if (c1 !== 2'b11) begin n_fail++; $display("FAIL 2_or_x got=%b exp=11", c1); end
    endtask

    task automatic test_pulse_capture();
        @(negedge clk);
        a1 = 2'b01; b1 = 2'b10; valid_i = 1'b1;
        step_edge();
        n_checks++;
        if (c_q1 !== 2'b10 || valid_o1 !== 1'b1) begin
            n_fail++; $display("FAIL pulse_capture c_q=%b valid_o=%b exp=10/1", c_q1, valid_o1);
        end
        @(negedge clk);
        a1 = 2'b00; b1 = 2'b01; valid_i = 1'b0;
        step_edge();
        n_checks++;
        if (c_q1 !== 2'b10 || valid_o1 !== 1'b0) begin
            n_fail++; $display("FAIL pulse_hold1 c_q=%b valid_o=%b exp=10/0", c_q1, valid_o1);
        end
        step_edge();
        n_checks++;
        if (c_q1 !== 2'b10 || valid_o1 !== 1'b0) begin
            n_fail++; $display("FAIL pulse_hold2 c_q=%b valid_o=%b exp=10/0", c_q1, valid_o1);
        end
    endtask

    task automatic test_async_reset();
        // c_q1 currently holds 2'b10
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        a1 = 2'b01; b1 = 2'b00;
        #1;
        n_checks++;
        if (c_q1 !== 2'b00 || valid_o1 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset c_q=%b valid_o=%b exp=00/0", c_q1, valid_o1);
        end
        n_checks++;
        if (c1 !== 2'b01) begin n_fail++; $display("FAIL async_reset_c_live got=%b exp=01", c1); end
`ifdef ORGATE_INVALID_CHECK_EN
        n_checks++;
        if (err1 !== 1'b0 || err_cnt1 !== 8'd0) begin
            n_fail++; $display("FAIL async_reset_err err=%b cnt=%0d exp=0/0", err1, err_cnt1);
        end
`endif
        // release mid-cycle with valid_i set: first edge captures
        #1;
        a1 = 2'b10; b1 = 2'b00; valid_i = 1'b1;
        rst_n = 1'b1;
        step_edge();
        n_checks++;
        if (c_q1 !== 2'b10 || valid_o1 !== 1'b1) begin
            n_fail++; $display("FAIL release_capture c_q=%b valid_o=%b exp=10/1", c_q1, valid_o1);
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_invalid();
        @(negedge clk);
        a1 = 2'b11; b1 = 2'b00; valid_i = 1'b1;
        #1;
        n_checks++;
        if (c1 !== 2'b11) begin n_fail++; $display("FAIL invalid_c got=%b exp=11", c1); end
        step_edge();
        n_checks++;
        if (c_q1 !== 2'b11) begin n_fail++; $display("FAIL invalid_c_q got=%b exp=11", c_q1); end
`ifdef ORGATE_INVALID_CHECK_EN
        n_checks++;
        if (err1 !== 1'b1 || err_cnt1 !== 8'd1) begin
            n_fail++; $display("FAIL invalid_err err=%b cnt=%0d exp=1/1", err1, err_cnt1);
        end
        n_checks++;
        if (err4 !== 1'b0) begin n_fail++; $display("FAIL invalid_err_w4 got=%b exp=0", err4); end
`endif
        @(negedge clk);
        valid_i = 1'b0; a1 = 2'b00;
        step_edge();
`ifdef ORGATE_INVALID_CHECK_EN
        n_checks++;
        if (err1 !== 1'b1 || err_cnt1 !== 8'd1) begin
            n_fail++; $display("FAIL err_sticky err=%b cnt=%0d exp=1/1", err1, err_cnt1);
        end
`endif
    endtask

    task automatic test_width4();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] ve [3];
        va = '{8'b10_01_00_01, 8'b11_00_10_01, 8'b10_10_10_10};
        vb = '{8'b00_01_10_00, 8'b00_00_01_01, 8'b00_00_00_00};
        ve = '{8'b10_01_10_01, 8'b11_00_10_01, 8'b10_10_10_10};
        for (int k = 0; k < 3; k++) begin
            a4 = va[k]; b4 = vb[k];
            #1;
            n_checks++;
            if (c4 !== ve[k]) begin
                n_fail++; $display("FAIL width4_c[%0d] got=%b exp=%b", k, c4, ve[k]);
            end
        end
        @(negedge clk);
        a4 = va[0]; b4 = vb[0]; valid_i = 1'b1;
        step_edge();
        n_checks++;
        if (c_q4 !== ve[0] || valid_o4 !== 1'b1) begin
            n_fail++; $display("FAIL width4_c_q got=%b/%b exp=%b/1", c_q4, valid_o4, ve[0]);
        end
        @(negedge clk);
        valid_i = 1'b0; a4 = 8'h00; b4 = 8'h00;
        step_edge();
        n_checks++;
        if (c_q4 !== ve[0]) begin n_fail++; $display("FAIL width4_hold got=%b exp=%b", c_q4, ve[0]); end
    endtask

`ifdef ORGATE_INVALID_CHECK_EN
    task automatic test_err_saturate();
        // dut1 counter is at 1 after test_invalid; reset to a known start
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a1 = 2'b11; b1 = 2'b00; valid_i = 1'b1;
        for (int k = 0; k < 10; k++) step_edge();
        n_checks++;
        if (err_cnt1 !== 8'd10) begin n_fail++; $display("FAIL err_cnt_10 got=%0d exp=10", err_cnt1); end
        for (int k = 10; k < 300; k++) step_edge();
        n_checks++;
        if (err_cnt1 !== 8'd255 || err1 !== 1'b1) begin
            n_fail++; $display("FAIL err_saturate err=%b cnt=%0d exp=1/255", err1, err_cnt1);
        end
        @(negedge clk);
        valid_i = 1'b0; a1 = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_pulse_capture();
        test_async_reset();
        test_invalid();
        test_width4();
`ifdef ORGATE_INVALID_CHECK_EN
        test_err_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_or_gate
